uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_os_baud_tick.sv | 31 +++
 rtl/uart_rx_os.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the oversampling UART receiver.
// Optional build macro: UART_RX_PARITY_EN adds an even-parity state between
// the data bits and the stop bit.
package uart_pkg;

    // Sample ticks per bit period and the tick on which the start bit is
    // re-checked (middle of the start bit).
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

    // Receiver frame states. PARITY only exists when parity checking is built in.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_t;

    // Clocks per oversample tick, truncating division, never below 1.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * OVERSAMPLE);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_rx_os_baud_tick.sv
// baud_tick: free-running divider producing a one-clock TICK every DIV
// clocks. CLR restarts the count so the first tick lands DIV clocks later.
module baud_tick #(
    parameter int DIV = 325
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CLR,
    output logic TICK
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIV-1, wrapping; reset and CLR both return to zero.
    always_ff @(posedge CLK) begin
        if (!RST_N || CLR) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A cleared divider never reports a tick in the clearing cycle.
    assign TICK = !CLR && (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling 8N1 UART receiver with a valid/ready output.
// Optional build macro: UART_RX_PARITY_EN (adds one even-parity bit, 8E1).
//
// Output handshake: VALID rises the clock after a good stop-bit sample and
// holds DATA until a clock edge sees VALID && READY; VALID then drops on that
// edge unless a new good frame completes on the same edge, in which case the
// new byte replaces DATA and VALID stays high. A good frame arriving while a
// byte is still unconsumed is dropped and OVR pulses for one clock.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RX_LINE,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       READY,
    output logic       BUSY,
    output logic       FERR,
    output logic       OVR
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);

    localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    // Synchronizer and edge history; all idle high.
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic fall;

    // FSM and datapath registers with their next values.
    rx_state_t  state;
    rx_state_t  state_nxt;
    logic [3:0] tick_cnt;
    logic [3:0] tick_cnt_nxt;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_nxt;
    logic [7:0] shift;
    logic [7:0] shift_nxt;

    // Divider control and per-frame outcome strobes.
    logic tick;
    logic tick_clr;
    logic frame_good;
    logic frame_bad;

    // Oversample tick generator, held cleared while idle.
    baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (tick_clr),
        .TICK  (tick)
    );

    // Two-flop synchronizer plus one history flop for falling-edge detect.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX_LINE;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev && !rx_sync;

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Tick counter, bit counter and shift register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            tick_cnt <= tick_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
        end
    end

    // Next-state and datapath decode; every sample point is the tick that
    // completes the count for the current state.
    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        tick_clr     = 1'b0;
        frame_good   = 1'b0;
        frame_bad    = 1'b0;

        case (state)
            ST_IDLE: begin
                // Keep the divider at zero so the start bit is timed from
                // the detected edge.
                tick_clr     = 1'b1;
                tick_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
                if (fall) begin
                    state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (tick_cnt == MID_LAST) begin
                        tick_cnt_nxt = '0;
                        // A line already back high was only a glitch.
                        state_nxt = rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_cnt_nxt = '0;
                        shift_nxt    = {rx_sync, shift[7:1]};
                        bit_cnt_nxt  = bit_cnt + 3'd1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = ST_PARITY;
`else
                            state_nxt = ST_STOP;
`endif
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_cnt_nxt = '0;
                        // Even parity: data bits plus parity bit XOR to 0.
                        if ((^shift) != rx_sync) begin
                            frame_bad = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_STOP;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end
`endif

            ST_STOP: begin
                if (tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_cnt_nxt = '0;
                        state_nxt    = ST_IDLE;
                        if (rx_sync) begin
                            frame_good = 1'b1;
                        end else begin
                            frame_bad = 1'b1;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign BUSY = (state != ST_IDLE);

    // Output holding register, handshake and error pulses. frame_good and
    // frame_bad are single-cycle strobes, so FERR/OVR can never stretch.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            DATA  <= 8'h00;
            VALID <= 1'b0;
            FERR  <= 1'b0;
            OVR   <= 1'b0;
        end else begin
            FERR <= frame_bad;
            OVR  <= 1'b0;
            if (frame_good) begin
                if (!VALID || READY) begin
                    DATA  <= shift;
                    VALID <= 1'b1;
                end else begin
                    OVR <= 1'b1;
                end
            end else if (VALID && READY) begin
                VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: self-checking bench for uart_rx_os.
// Optional build macro: UART_RX_PARITY_EN (bench then sends a parity bit).
module tb_uart_rx_os;

    // 9600 baud with a clock giving 10 clocks per oversample tick.
    localparam int CLK_HZ   = 1536000;
    localparam int BAUD     = 9600;
    localparam int BIT_CLKS = CLK_HZ / BAUD;
    localparam int GAP_CLKS = 40;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       RX_LINE = 1'b1;
    logic       READY = 1'b0;
    logic [7:0] DATA;
    logic       VALID;
    logic       BUSY;
    logic       FERR;
    logic       OVR;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    logic ferr_q = 1'b0;
    logic ovr_q  = 1'b0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

`ifdef UART_RX_PARITY_EN
    bit par_bad = 1'b0;
`endif

    uart_rx_os #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .RX_LINE (RX_LINE),
        .DATA    (DATA),
        .VALID   (VALID),
        .READY   (READY),
        .BUSY    (BUSY),
        .FERR    (FERR),
        .OVR     (OVR)
    );

    // Clock and watchdog.
    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: counts error pulses, checks their width, captures handshakes.
    always @(negedge CLK) begin
        #1;
        if (FERR) begin
            n_checks++;
            ferr_cnt++;
            if (ferr_q) begin
                n_fail++;
                $display("FAIL ferr_width: got 2+ cycles required 1");
            end
        end
        if (OVR) begin
            n_checks++;
            ovr_cnt++;
            if (ovr_q) begin
                n_fail++;
                $display("FAIL ovr_width: got 2+ cycles required 1");
            end
        end
        ferr_q = FERR;
        ovr_q  = OVR;
        if (RST_N && VALID && READY) begin
            got_q.push_back(DATA);
        end
    end

    // Driver tasks.
    task automatic idle_clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        RX_LINE = 1'b0;
        idle_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            RX_LINE = b[i];
            idle_clks(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        RX_LINE = (^b) ^ par_bad;
        idle_clks(BIT_CLKS);
`endif
        RX_LINE = stop_bit;
        idle_clks(BIT_CLKS);
        RX_LINE = 1'b1;
        idle_clks(GAP_CLKS);
    endtask

    task automatic flush();
        READY = 1'b1;
        idle_clks(3);
        READY = 1'b0;
        idle_clks(1);
    endtask

    // Finds the clock where BUSY falls and checks VALID rose on that same edge.
    task automatic watch_latency(input logic [7:0] b);
        logic pb;
        logic pv;
        bit   seen;
        seen = 1'b0;
        pb = BUSY;
        pv = VALID;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge CLK);
            #1;
            if (pb && !BUSY) begin
                seen = 1'b1;
                check("lat_valid_before", {31'd0, pv}, 32'd0);
                check("lat_valid_after", {31'd0, VALID}, 32'd1);
                check("lat_data", {24'd0, DATA}, {24'd0, b});
            end
            pb = BUSY;
            pv = VALID;
        end
        if (!seen) begin
            check("lat_timeout", 32'd0, 32'd1);
        end
    endtask

    typedef struct {
        bit         glitch;
        logic [7:0] b;
        bit         stop_bit;
        bit         ready;
        bit         do_flush;
        bit         e_valid;
        logic [7:0] e_data;
        int         e_ferr;
        int         e_ovr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int f0;
        int o0;
        bit pend_v;
        logic [7:0] pend_d;
        int exp_ferr;
        int exp_ovr;

        vecs[0] = '{1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 0, 0};
        vecs[1] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 0, 0};
        vecs[2] = '{1'b0, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1, 0};
        vecs[3] = '{1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 0, 0};
        vecs[4] = '{1'b0, 8'h34, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 0, 1};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0};
        vecs[6] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 0, 0};

        // Reset state.
        idle_clks(5);
        check("rst_data", {24'd0, DATA}, 32'd0);
        check("rst_valid", {31'd0, VALID}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_ferr", {31'd0, FERR}, 32'd0);
        check("rst_ovr", {31'd0, OVR}, 32'd0);
        RST_N = 1'b1;
        idle_clks(20);

        // Table-driven vectors.
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].do_flush) begin
                flush();
            end
            READY = vecs[v].ready;
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            if (vecs[v].glitch) begin
                RX_LINE = 1'b0;
                idle_clks(40);
                RX_LINE = 1'b1;
                check("glitch_busy", {31'd0, BUSY}, 32'd1);
                idle_clks(200);
            end else begin
                send_frame(vecs[v].b, vecs[v].stop_bit);
            end
            check($sformatf("v%0d_valid", v), {31'd0, VALID}, {31'd0, vecs[v].e_valid});
            check($sformatf("v%0d_data", v), {24'd0, DATA}, {24'd0, vecs[v].e_data});
            check($sformatf("v%0d_ferr", v), ferr_cnt - f0, vecs[v].e_ferr);
            check($sformatf("v%0d_ovr", v), ovr_cnt - o0, vecs[v].e_ovr);
            check($sformatf("v%0d_busy", v), {31'd0, BUSY}, 32'd0);
            READY = 1'b0;
        end

        // Latency: VALID rises on the edge the FSM leaves STOP.
        flush();
        fork
            send_frame(8'h5A, 1'b1);
            watch_latency(8'h5A);
        join

        // Reset mid-frame during bit 3 of 0xFF, then 0x0F.
        flush();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle_clks(BIT_CLKS * 4 + BIT_CLKS / 2);
                RST_N = 1'b0;
                idle_clks(1);
                RST_N = 1'b1;
                check("midrst_busy", {31'd0, BUSY}, 32'd0);
                check("midrst_data", {24'd0, DATA}, 32'd0);
                check("midrst_valid", {31'd0, VALID}, 32'd0);
            end
        join
        check("midrst_no_frame", {31'd0, VALID}, 32'd0);
        send_frame(8'h0F, 1'b1);
        check("after_rst_valid", {31'd0, VALID}, 32'd1);
        check("after_rst_data", {24'd0, DATA}, 32'h0F);
        check("after_rst_ferr", ferr_cnt - f0, 32'd0);
        check("after_rst_ovr", ovr_cnt - o0, 32'd0);

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 has odd weight so the even-parity bit must be 1.
        flush();
        f0 = ferr_cnt;
        par_bad = 1'b1;
        send_frame(8'h07, 1'b1);
        check("par_bad_ferr", ferr_cnt - f0, 32'd1);
        check("par_bad_valid", {31'd0, VALID}, 32'd0);
        par_bad = 1'b0;
        send_frame(8'h07, 1'b1);
        check("par_ok_valid", {31'd0, VALID}, 32'd1);
        check("par_ok_data", {24'd0, DATA}, 32'h07);
`endif

        // Randomized frames against a byte-level delivery model.
        flush();
        got_q.delete();
        exp_q.delete();
        pend_v = 1'b0;
        pend_d = 8'h00;
        exp_ferr = 0;
        exp_ovr = 0;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        for (int n = 0; n < 12; n++) begin
            logic [7:0] b;
            bit rdy;
            bit good;
            b    = 8'($urandom_range(0, 255));
            rdy  = 1'($urandom_range(0, 1));
            good = ($urandom_range(0, 7) != 0);
            if (rdy && pend_v) begin
                exp_q.push_back(pend_d);
                pend_v = 1'b0;
            end
            if (!good) begin
                exp_ferr++;
            end else if (rdy) begin
                exp_q.push_back(b);
            end else if (pend_v) begin
                exp_ovr++;
            end else begin
                pend_v = 1'b1;
                pend_d = b;
            end
            READY = rdy;
            send_frame(b, good);
            idle_clks(int'($urandom_range(0, 30)));
        end
        if (pend_v) begin
            exp_q.push_back(pend_d);
        end
        flush();
        check("rand_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("rand_byte%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
        check("rand_ferr", ferr_cnt - f0, exp_ferr);
        check("rand_ovr", ovr_cnt - o0, exp_ovr);
        check("rand_end_valid", {31'd0, VALID}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
